// File: rtl/ram_bist_sequencer.sv
// ram_bist_sequencer
// Memory self-test initiator for a single-port RAM with registered read data.
// A start pulse (taken only in IDLE or DONE) writes pattern(addr) =
// (addr + SEED) mod 2**DATA_WIDTH to every address. It then reads each word
// back and compares it. The test stops at the first mismatch, or after the
// last address matches.
//
// Optional feature (define INVERT_PASS_EN): after a clean first pass, a
// second write/read pass runs with the inverted pattern. The extra output
// pass_phase shows which pass the result belongs to (0 = first, 1 = second).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle test request (ignored while busy)
//   ram_rd_data  RAM read data, valid the cycle after the address is shown
//   ram_wr_n     RAM write enable, active low
//   ram_addr     RAM address
//   ram_wr_data  RAM write data
//   busy         test in progress
//   done         sticky end-of-test flag, cleared by the next accepted start
//   pass         1 = no mismatch (valid while done)
//   fail_addr    first mismatching address (0 on pass)
//   fail_data    data read at fail_addr (0 on pass)
//   pass_phase   (INVERT_PASS_EN only) pass that produced the result
//   state_dbg    current FSM state, for debug visibility
//
// Handshake: start is a single-cycle strobe with no acknowledge. A strobe
// that arrives in WRITE, RD_ISSUE or RD_CHECK is dropped.
// Every output is a register. The next value of each output is computed
// from the next state, so ram_addr and ram_wr_n are already valid in the
// first cycle of each state.
module ram_bist_sequencer #(
  parameter int DATA_WIDTH    = 5,
  parameter int ADDRESS_WIDTH = 5,
  parameter int SEED          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data,
  output logic                     ram_wr_n,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ADDRESS_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_data,
`ifdef INVERT_PASS_EN
  output logic                     pass_phase,
`endif
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CHECK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  // Address truncated or zero-extended to the data width, plus the seed,
  // optionally inverted for the second pass.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDRESS_WIDTH-1:0] a,
    input logic                     inv
  );
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) + DATA_WIDTH'(SEED);
    if (inv) p = ~p;
    return p;
  endfunction

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     phase_q, phase_d;
  logic                     wr_n_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]    wdata_d;
  logic                     busy_d, done_d, pass_d;
  logic [ADDRESS_WIDTH-1:0] faddr_d;
  logic [DATA_WIDTH-1:0]    fdata_d;

  logic [ADDRESS_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0]    exp_word;
  logic                     last;

  assign nxt_addr = cnt_q + ADDR_ONE;
  assign exp_word = pattern(cnt_q, phase_q);
  // Terminal test on the all-ones address, so the counter never wraps to 0
  // and never rewrites address 0.
  assign last     = &cnt_q;

  assign state_dbg = state_q;
`ifdef INVERT_PASS_EN
  assign pass_phase = phase_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      ram_wr_n    <= 1'b1;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      ram_wr_n    <= wr_n_d;
      ram_addr    <= addr_d;
      ram_wr_data <= wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fail_addr   <= faddr_d;
      fail_data   <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    wr_n_d  = 1'b1;
    addr_d  = ram_addr;
    wdata_d = ram_wr_data;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    faddr_d = fail_addr;
    fdata_d = fail_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          cnt_d   = '0;
          phase_d = 1'b0;
          wr_n_d  = 1'b0;
          addr_d  = '0;
          wdata_d = pattern('0, 1'b0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
        end
      end

      // The outputs show the write for cnt_q during this cycle.
      S_WRITE: begin
        if (last) begin
          state_d = S_RD_ISSUE;
          cnt_d   = '0;
          addr_d  = '0;
        end else begin
          cnt_d   = nxt_addr;
          wr_n_d  = 1'b0;
          addr_d  = nxt_addr;
          wdata_d = pattern(nxt_addr, phase_q);
        end
      end

      // The address is on the bus now. The RAM returns the word next cycle.
      S_RD_ISSUE: begin
        state_d = S_RD_CHECK;
      end

      S_RD_CHECK: begin
        if (ram_rd_data != exp_word) begin
          state_d = S_DONE;
          faddr_d = cnt_q;
          fdata_d = ram_rd_data;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (last) begin
`ifdef INVERT_PASS_EN
          if (!phase_q) begin
            state_d = S_WRITE;
            phase_d = 1'b1;
            cnt_d   = '0;
            wr_n_d  = 1'b0;
            addr_d  = '0;
            wdata_d = pattern('0, 1'b1);
          end else
`endif
          begin
            state_d = S_DONE;
            pass_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_RD_ISSUE;
          cnt_d   = nxt_addr;
          addr_d  = nxt_addr;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench for ram_bist_sequencer (DW=5, AW=5).
// u_dut0 (SEED=0) sits beside a RAM model whose read path can inject one
// stuck-at bit. u_dut7 (SEED=7) has an ideal RAM and is checked after the
// first test only.
module tb_ram_bist_sequencer;
  localparam int DW    = 5;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int W     = AW + DW;
`ifdef INVERT_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [DW-1:0] rd0, rd7;
  logic          wr_n0, wr_n7;
  logic [AW-1:0] addr0, addr7;
  logic [DW-1:0] wdata0, wdata7;
  logic          busy0, busy7, done0, done7, pass0, pass7;
  logic [AW-1:0] faddr0, faddr7;
  logic [DW-1:0] fdata0, fdata7;
  logic [2:0]    dbg0, dbg7;
`ifdef INVERT_PASS_EN
  logic          phase0, phase7;
`endif

  ram_bist_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SEED(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .ram_rd_data(rd0),
    .ram_wr_n(wr_n0), .ram_addr(addr0), .ram_wr_data(wdata0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_addr(faddr0), .fail_data(fdata0),
`ifdef INVERT_PASS_EN
    .pass_phase(phase0),
`endif
    .state_dbg(dbg0)
  );

  ram_bist_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SEED(7)) u_dut7 (
    .clk(clk), .rst(rst), .start(start), .ram_rd_data(rd7),
    .ram_wr_n(wr_n7), .ram_addr(addr7), .ram_wr_data(wdata7),
    .busy(busy7), .done(done7), .pass(pass7),
    .fail_addr(faddr7), .fail_data(fdata7),
`ifdef INVERT_PASS_EN
    .pass_phase(phase7),
`endif
    .state_dbg(dbg7)
  );

  // ---------------- RAM models ----------------
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem7 [DEPTH];
  bit fault_en;
  int fault_addr, fault_bit, fault_val;

  function automatic int faulty(input int a, input int stored);
    int m;
    if (fault_en && a == fault_addr) begin
      m = 1 << fault_bit;
      return fault_val ? (stored | m) : (stored & ~m);
    end
    return stored;
  endfunction

  always @(posedge clk) begin
    if (wr_n0 === 1'b0) mem0[addr0] <= wdata0;
    rd0 <= DW'(faulty(int'(addr0), int'(mem0[addr0])));
    if (wr_n7 === 1'b0) mem7[addr7] <= wdata7;
    rd7 <= mem7[addr7];
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int wr_lows, wr_bad, max_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each observed write is matched against the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wr_n0 === 1'b0) begin
        wr_lows++;
        if (busy0 !== 1'b1) wr_bad++;
        check("write_seq", {22'd0, addr0, wdata0},
              (exp_q.size() > 0) ? {22'd0, exp_q.pop_front()} : 32'hFFFF_FFFF);
      end else if (busy0 === 1'b1 && int'(addr0) > max_rd) begin
        max_rd = int'(addr0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int pat(input int a, input int seed, input int p);
    int v;
    v = (a + seed) % 32;
    return (p != 0) ? (31 - v) : v;
  endfunction

  int exp_pass, exp_faddr, exp_fdata, exp_lat, exp_phase, exp_entered, exp_max_rd;

  // Derives the outcome from the test rules: one pass = 32 writes, then
  // 2 cycles per address read, stopping at the first bad word.
  task automatic build_model();
    bit found;
    int s, r;
    found = 0;
    exp_pass = 1; exp_faddr = 0; exp_fdata = 0; exp_lat = 0;
    exp_phase = NP - 1; exp_entered = 0; exp_max_rd = DEPTH - 1;
    for (int p = 0; p < NP; p++) begin
      if (found) break;
      exp_entered++;
      exp_lat += DEPTH;
      for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), DW'(pat(a, 0, p))});
      for (int a = 0; a < DEPTH; a++) begin
        exp_lat += 2;
        s = pat(a, 0, p);
        r = faulty(a, s);
        if (r != s) begin
          found = 1; exp_pass = 0; exp_faddr = a; exp_fdata = r; exp_phase = p;
          if (p == 0) exp_max_rd = a;
          break;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  int last_done_cyc;

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_test(input int idle, input bit pulses, input bit do_rst);
    int s, n;
    exp_q.delete();
    build_model();
    wr_lows = 0; wr_bad = 0; max_rd = 0;
    repeat (idle) begin @(posedge clk); #1; end
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", {31'd0, busy0}, 32'd1);
    check("accept_done_clr", {31'd0, done0}, 32'd0);
    n = 0;
    while (done0 !== 1'b1 && n < 400) begin
      start = pulses && (cyc == s + 5 || cyc == s + 53);
      if (do_rst && cyc == s + 72) begin
        check("read_issue_addr20", {26'd0, wr_n0, addr0}, {26'd0, 1'b1, 5'd20});
        #2 rst = 1'b1;
        #1;
        check("rst_async_wr_n", {31'd0, wr_n0}, 32'd1);
        check("rst_async_busy", {31'd0, busy0}, 32'd0);
        check("rst_async_done", {31'd0, done0}, 32'd0);
        check("rst_async_addr", {27'd0, addr0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (n >= 400) check("done_timeout", 32'd0, 32'd1);
    last_done_cyc = cyc;
    check("done_cycle", cyc, s + exp_lat);
    check("pass", {31'd0, pass0}, exp_pass);
    check("fail_addr", {27'd0, faddr0}, exp_faddr);
    check("fail_data", {27'd0, fdata0}, exp_fdata);
    check("busy_at_done", {31'd0, busy0}, 32'd0);
    check("wr_n_at_done", {31'd0, wr_n0}, 32'd1);
    check("writes_left", exp_q.size(), 32'd0);
    check("write_cycles", wr_lows, DEPTH * exp_entered);
    check("wr_n_outside_write", wr_bad, 32'd0);
    check("max_read_addr", max_rd, exp_max_rd);
`ifdef INVERT_PASS_EN
    check("pass_phase", {31'd0, phase0}, exp_phase);
`endif
    repeat (3) begin @(posedge clk); #1; end
    check("done_sticky", {30'd0, done0, pass0}, {30'd0, 1'b1, exp_pass[0]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad7;
    rst = 1'b1; start = 1'b0; fault_en = 0;
    fault_addr = 0; fault_bit = 0; fault_val = 0;
    for (int i = 0; i < DEPTH; i++) begin mem0[i] = '0; mem7[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_n", {31'd0, wr_n0}, 32'd1);
    check("rst_addr", {27'd0, addr0}, 32'd0);
    check("rst_wdata", {27'd0, wdata0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_pass", {31'd0, pass0}, 32'd0);
    check("rst_fail_addr", {27'd0, faddr0}, 32'd0);
    check("rst_fail_data", {27'd0, fdata0}, 32'd0);
    rst = 1'b0;
    while (cyc < 10) begin @(posedge clk); #1; end

    // Ideal RAM, start raised in cycle 10.
    run_test(0, 0, 0);
    check("first_done_cycle", last_done_cyc, 107 + (NP - 1) * 96);
    bad7 = 0;
    for (int a = 0; a < DEPTH; a++)
      if (int'(mem7[a]) != pat(a, 7, NP - 1)) bad7++;
    check("seed7_mem_errors", bad7, 0);
    check("seed7_addr30", {27'd0, mem7[30]}, pat(30, 7, NP - 1));
    check("seed7_done_pass", {30'd0, done7, pass7}, 32'd3);

    // Address 13 bit 2 stuck at 1.
    fault_en = 1; fault_addr = 13; fault_bit = 2; fault_val = 1;
    run_test(3, 0, 0);

    // start strobes during WRITE (address 5) and during RD_CHECK are ignored.
    fault_en = 0;
    run_test(2, 1, 0);

    // Address 3 bit 2 stuck at 0: shows only with the inverted pattern.
    fault_en = 1; fault_addr = 3; fault_bit = 2; fault_val = 0;
    run_test(2, 0, 0);

    // Reset while reading address 20, then a clean full test.
    fault_en = 0;
    run_test(2, 0, 1);
    run_test(2, 0, 0);

    // Randomized faults.
    for (int i = 0; i < 6; i++) begin
      fault_en   = bit'($urandom_range(0, 1));
      fault_addr = $urandom_range(0, DEPTH - 1);
      fault_bit  = $urandom_range(0, DW - 1);
      fault_val  = $urandom_range(0, 1);
      run_test($urandom_range(1, 5), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
